// File: rtl/sum_pkg.sv
// Shared types, default widths and helpers for the sum accumulator block.
package sum_pkg;

    // Frame state: collecting samples, or presenting a finished total.
    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } sum_state_e;

    // Default adder sum-field width and accumulator width.
    localparam int SUM_IN_W  = 3;
    localparam int SUM_ACC_W = 8;

    // Working width for the input extension helper; callers cast down.
    localparam int SUM_EXT_W = 32;

    // Builds the unsigned value {carry, sum} with the carry sitting just
    // above an in_w-bit sum field, zero-extended to SUM_EXT_W bits.
    function automatic logic [SUM_EXT_W-1:0] sum_extend(
        input logic                 carry,
        input logic [SUM_EXT_W-1:0] sum,
        input int unsigned          in_w
    );
        return sum | (SUM_EXT_W'(carry) << in_w);
    endfunction

endpackage

// File: rtl/sum_accum_core.sv
// Combinational add-and-overflow datapath for sum_accum.
// Build option: SUM_ACCUM_SAT_EN selects saturation instead of wrap on overflow.
module sum_accum_core
    import sum_pkg::*;
#(
    parameter int ACC_W = SUM_ACC_W
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [ACC_W:0]   value_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             ovf_o
);

    logic [ACC_W:0] nxt;

    // One extra bit of headroom exposes the carry out of the accumulator.
    always_comb begin
        nxt   = {1'b0, acc_i} + value_i;
        ovf_o = nxt[ACC_W];
`ifdef SUM_ACCUM_SAT_EN
        // Clamp to all-ones; adding a non-negative value to all-ones keeps it there.
        acc_o = nxt[ACC_W] ? {ACC_W{1'b1}} : nxt[ACC_W-1:0];
`else
        acc_o = nxt[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/sum_accum.sv
// Frame accumulator: sums COUNT adder results, then presents the total with
// an overflow flag over a valid/ready handshake.
// Build option: SUM_ACCUM_SAT_EN (saturating accumulate, see sum_accum_core).
module sum_accum
    import sum_pkg::*;
#(
    parameter int IN_W  = SUM_IN_W,
    parameter int ACC_W = SUM_ACC_W,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [IN_W-1:0]  in_sum,
    input  logic             in_carry,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    sum_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W:0]   in_value;
    logic [ACC_W-1:0] acc_next;
    logic             add_ovf;
    logic             accept;

    // Handshake signals decode from state only, so neither ready nor valid
    // has a combinational path from the opposite side's valid/ready.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign accept    = in_valid && in_ready;

    // Zero-extended {carry, sum}; ACC_W >= IN_W+1 guarantees it fits.
    assign in_value = (ACC_W+1)'(sum_extend(in_carry, SUM_EXT_W'(in_sum), IN_W));

    sum_accum_core #(
        .ACC_W (ACC_W)
    ) u_core (
        .acc_i   (acc_q),
        .value_i (in_value),
        .acc_o   (acc_next),
        .ovf_o   (add_ovf)
    );

    // Next-state and datapath update; clr takes priority over any handshake.
    always_comb begin
        // NOTE: every output gets a hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_sum_d = out_sum_q;
        out_ovf_d = out_ovf_q;

        if (clr) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_d = acc_next;
                        ovf_d = ovf_q | add_ovf;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_d   = DONE;
                            cnt_d     = '0;
                            out_sum_d = acc_next;
                            out_ovf_d = ovf_q | add_ovf;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_sum_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_sum_q <= out_sum_d;
            out_ovf_q <= out_ovf_d;
        end
    end

endmodule

// File: doc/sum_accum.md
Name: sum_accum

Overview:
- Downstream consumer of the 3-bit sum/carry adder stage.
- Takes each {carry, sum} result through a valid/ready handshake and accumulates COUNT results into a wider running total.
- Presents the frame total with an overflow flag through a second valid/ready handshake, then starts the next frame.
- Lets the adder feed longer reductions without widening the adder.

Parameters:
IN_W, 3, width of adder sum field; input value is {in_carry, in_sum}, IN_W+1 bits, range 0..2^(IN_W+1)-2
ACC_W, 8, accumulator/output width; legal range ACC_W >= IN_W+1
COUNT, 4, accepted samples per frame; legal range COUNT >= 1

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous frame abort/clear
in_sum  in  IN_W  sum field from adder
in_carry  in  1  carry from adder
in_valid  in  1  input sample valid
in_ready  out  1  block accepts sample this cycle
out_sum  out  ACC_W  frame total
out_ovf  out  1  frame overflowed ACC_W
out_valid  out  1  frame result valid
out_ready  in  1  consumer takes result

Behaviour:
- Reset (async, immediate, no clock edge needed) sets the following:
  - state=ACCUM, acc=0, cnt=0.
  - out_sum=0, out_ovf=0, out_valid=0.
  - in_ready=1, because in_ready is decoded from state.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept condition: in_valid && in_ready. Cycles with in_valid=0 change nothing.
- On accept in ACCUM:
  - Compute nxt = acc + zero-extend({in_carry,in_sum}) at ACC_W+1 bits.
  - If nxt[ACC_W]=1, set ovf (sticky within frame).
  - acc <= nxt[ACC_W-1:0] (wrap).
  - cnt <= cnt+1.
- Frame end, when the accepted sample has cnt==COUNT-1:
  - Next cycle: state=DONE, out_sum=final acc, out_ovf=final ovf, out_valid=1.
  - Latency: 1 cycle from last accept to out_valid.
- In DONE, out_sum and out_ovf are held stable while out_valid && !out_ready. in_valid is ignored.
- On out_valid && out_ready:
  - Next cycle: acc=0, cnt=0, ovf=0, out_valid=0, state=ACCUM.
  - out_sum and out_ovf keep their last values; they are don't-care while out_valid=0.
  - No input is accepted in the same cycle as the handshake (in_ready=0 in DONE). Minimum frame period is COUNT+1 cycles.
- clr=1 at a clock edge:
  - acc=0, cnt=0, ovf=0, out_valid=0, state=ACCUM.
  - Overrides any same-cycle accept or output handshake; a pending DONE result is discarded.
- COUNT=1: every accept goes straight to DONE.
- cnt width: $clog2(COUNT), minimum 1.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Optional Feature:
Macro SUM_ACCUM_SAT_EN.
- Defined: on accept with nxt[ACC_W]=1, acc clamps to 2^ACC_W-1 and ovf is set. A saturated acc stays saturated for the rest of the frame.
- Undefined: acc wraps modulo 2^ACC_W and ovf is set (as above).
- All other behaviour is identical in both builds.

Decomposition:
- Shared package sum_pkg holds:
  - state enum {ACCUM, DONE}
  - default widths SUM_IN_W=3, SUM_ACC_W=8
  - helper function for input value extension
- One natural sub-module, sum_accum_core: the combinational add-and-overflow/saturate datapath (acc, value -> next acc, ovf). The FSM and counter stay in sum_accum.

Test Plan:
1. Defaults. Feed (0,0), (0,1), (7,0), (3,0) as {in_sum,in_carry}, i.e. values 0, 8, 7, 3, out_ready=1 -> out_valid one cycle after 4th accept, out_sum=18, out_ovf=0, next cycle in_ready=1.
2. Hold out_ready=0 for 5 cycles after DONE while in_valid=1 -> out_valid and out_sum=18 stable, in_ready=0, no samples consumed. Raising out_ready -> back to ACCUM, next frame starts from 0.
3. ACC_W=5, four samples of value 14 (in_sum=6, in_carry=1):
   - Wrap build -> out_sum=24, out_ovf=1.
   - SUM_ACCUM_SAT_EN build -> out_sum=31, out_ovf=1.
4. Random in_valid gaps (1-3 idle cycles) between four samples of value 5 -> out_sum=20; idle cycles not counted.
5. Accept 2 samples of 9, pulse clr, then 4 samples of 1 -> out_sum=4, out_ovf=0. Also assert clr in DONE with out_ready=1 -> result discarded, state ACCUM.
6. Assert rst asynchronously mid-frame, between clock edges -> out_valid, out_sum and out_ovf go 0 immediately. After release, a fresh 4-sample frame totals correctly.
